la_acquire: RTL and testbench

- Acquisition controller directly downstream of the LA trigger stage.
- Consumes the trigger stage's aligned output stream and per-beat trigger vector.
- Gates the stream into one acquisition packet: programmable pre-trigger depth, trigger wait, programmable post-trigger length, TLAST on the final beat.
- Feeds the stream-to-memory writer; status registers go to the register bank.

---
 rtl/la_acquire_if.sv | 36 +++
 rtl/la_acquire.sv | 163 ++++++++++++++++
 tb/tb_la_acquire.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/la_acquire_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : axi4_stream_if
// Brief    : AXI4-Stream channel; d = sink-side view, s = source-side view.
// Revision : 1.0
//------------------------------------------------------------------------------
interface axi4_stream_if #(
   parameter int DW = 32
) (
   input logic ACLK,
   input logic ARESETn
);
   logic            TVALID;
   logic            TREADY;
   logic            TLAST;
   logic [DW-1:0]   TDATA;
   logic [DW/8-1:0] TKEEP;

   modport d (
      input  ACLK,
      input  ARESETn,
      input  TVALID,
      input  TDATA,
      input  TKEEP,
      output TREADY
   );

   modport s (
      output TVALID,
      output TDATA,
      output TKEEP,
      output TLAST,
      input  TREADY
   );
endinterface
`default_nettype wire

// File: rtl/la_acquire.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : la_acquire
// Brief    : Gates the trigger-aligned stream into one acquisition packet
//            (pre-trigger fill, trigger wait, post-trigger run, TLAST).
//            Optional LA_ACQUIRE_TIMESTAMP_EN adds the sts_tim trigger stamp.
// Revision : 1.0
//------------------------------------------------------------------------------
module la_acquire #(
   parameter int TN = 4,
   parameter int CW = 32,
   parameter int DN = 1
) (
   input  logic          ctl_rst,
   input  logic          ctl_acq,
   input  logic          ctl_stp,
   input  logic          ctl_trg,
   input  logic [TN-1:0] cfg_trg,
   input  logic [CW-1:0] cfg_pre,
   input  logic [CW-1:0] cfg_pst,
   input  logic [TN-1:0] trg_in,
   output logic          sts_acq,
   output logic          sts_trg,
   output logic [CW-1:0] sts_pre,
   output logic [CW-1:0] sts_pst,
`ifdef LA_ACQUIRE_TIMESTAMP_EN
   output logic [63:0]   sts_tim,
`endif
   axi4_stream_if.d      sti,
   axi4_stream_if.s      sto
);
   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_pre  = 2'd1;
   localparam logic [1:0] c_arm  = 2'd2;
   localparam logic [1:0] c_pst  = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic          r_trg;
   logic          r_pend;
   logic [CW-1:0] r_pre;
   logic [CW-1:0] r_pst;
   logic          w_xfer;
   logic          w_event;
   logic          w_hold;
   logic          w_start;
   logic          w_trg_beat;
   logic [CW-1:0] w_pre_inc;

   if (DN < 1) begin : g_dn_chk
      $error("la_acquire: DN must be at least 1");
   end

   assign w_xfer     = sti.TVALID & sti.TREADY;
   assign w_event    = (|(trg_in & cfg_trg & {TN{sti.TVALID}})) | ctl_trg;
   assign w_hold     = ctl_rst | ctl_stp;
   assign w_start    = (r_state == c_idle) & ctl_acq & ~ctl_rst;
   assign w_trg_beat = (r_state == c_arm) & w_xfer & (w_event | r_pend) & ~w_hold;
   assign w_pre_inc  = r_pre + 1'b1;

   always_ff @(posedge sti.ACLK or negedge sti.ARESETn) begin
      if (!sti.ARESETn) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (ctl_rst) begin
         w_state_nxt = c_idle;
      end else if (ctl_stp && (r_state != c_idle)) begin
         w_state_nxt = c_idle;
      end else begin
         case (r_state)
            c_idle: if (ctl_acq) w_state_nxt = (cfg_pre != '0) ? c_pre : c_arm;
            c_pre:  if (w_xfer && (w_pre_inc == cfg_pre)) w_state_nxt = c_arm;
            c_arm:  if (w_trg_beat) w_state_nxt = (cfg_pst == '0) ? c_idle : c_pst;
            c_pst:  if (w_xfer && (r_pst == cfg_pst)) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
         endcase
      end
   end

   // TLAST follows TVALID, not the handshake, so it is stable under backpressure.
   always_comb begin
      sts_acq    = (r_state != c_idle);
      sto.TVALID = sts_acq & sti.TVALID;
      sti.TREADY = sts_acq ? sto.TREADY : 1'b1;
      sto.TLAST  = 1'b0;
      if (sti.TVALID && !w_hold) begin
         if (r_state == c_arm) begin
            sto.TLAST = (w_event | r_pend) & (cfg_pst == '0);
         end else if (r_state == c_pst) begin
            sto.TLAST = (r_pst == cfg_pst);
         end
      end
   end

   assign sto.TDATA = sti.TDATA;
   assign sto.TKEEP = sti.TKEEP;

   always_ff @(posedge sti.ACLK or negedge sti.ARESETn) begin
      if (!sti.ARESETn) begin
         r_trg  <= 1'b0;
         r_pend <= 1'b0;
         r_pre  <= '0;
         r_pst  <= '0;
      end else if (ctl_rst || w_start) begin
         r_trg  <= 1'b0;
         r_pend <= 1'b0;
         r_pre  <= '0;
         r_pst  <= '0;
      end else if (!ctl_stp) begin
         case (r_state)
            c_pre: begin
               if (w_xfer) r_pre <= w_pre_inc;
            end
            c_arm: begin
               if (w_trg_beat) begin
                  r_trg  <= 1'b1;
                  r_pst  <= {{(CW-1){1'b0}}, 1'b1};
                  r_pend <= 1'b0;
               end else begin
                  if (w_event) r_pend <= 1'b1;
                  if (w_xfer && (r_pre != '1)) r_pre <= w_pre_inc;
               end
            end
            c_pst: begin
               if (w_xfer) r_pst <= r_pst + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sts_trg = r_trg;
   assign sts_pre = r_pre;
   assign sts_pst = r_pst;

`ifdef LA_ACQUIRE_TIMESTAMP_EN
   logic [63:0] r_tim_cnt;
   logic [63:0] r_tim;

   always_ff @(posedge sti.ACLK or negedge sti.ARESETn) begin
      if (!sti.ARESETn) begin
         r_tim_cnt <= '0;
         r_tim     <= '0;
      end else begin
         r_tim_cnt <= r_tim_cnt + 64'd1;
         if (ctl_rst || w_start) begin
            r_tim <= '0;
         end else if (w_trg_beat) begin
            r_tim <= r_tim_cnt;
         end
      end
   end

   assign sts_tim = r_tim;
`endif
endmodule
`default_nettype wire

// File: tb/tb_la_acquire.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_la_acquire
// Brief    : Scoreboard bench for la_acquire: packet-level reference model
//            queues expected beats, an output monitor pops and compares.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_la_acquire;
   localparam int TN = 4;
   localparam int CW = 8;
   localparam int DW = 32;
   localparam int c_sat = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          ctl_rst, ctl_acq, ctl_stp, ctl_trg;
   logic [TN-1:0] cfg_trg, trg_in;
   logic [CW-1:0] cfg_pre, cfg_pst;
   logic          sts_acq, sts_trg;
   logic [CW-1:0] sts_pre, sts_pst;
`ifdef LA_ACQUIRE_TIMESTAMP_EN
   logic [63:0]   sts_tim;
`endif

   axi4_stream_if #(.DW(DW)) sti_if (.ACLK(clk), .ARESETn(rst_n));
   axi4_stream_if #(.DW(DW)) sto_if (.ACLK(clk), .ARESETn(rst_n));

   la_acquire #(.TN(TN), .CW(CW), .DN(1)) dut (
      .ctl_rst (ctl_rst),
      .ctl_acq (ctl_acq),
      .ctl_stp (ctl_stp),
      .ctl_trg (ctl_trg),
      .cfg_trg (cfg_trg),
      .cfg_pre (cfg_pre),
      .cfg_pst (cfg_pst),
      .trg_in  (trg_in),
      .sts_acq (sts_acq),
      .sts_trg (sts_trg),
      .sts_pre (sts_pre),
      .sts_pst (sts_pst),
`ifdef LA_ACQUIRE_TIMESTAMP_EN
      .sts_tim (sts_tim),
`endif
      .sti     (sti_if),
      .sto     (sto_if)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t           exp_q[$];
   int              n_checks = 0;
   int              n_errors = 0;
   int              n_last   = 0;
   int              l0;
   longint unsigned cyc;

   // Reference model: packet progress expressed as counts, not states.
   bit              m_active = 0;
   bit              m_trg    = 0;
   bit              m_pend   = 0;
   int unsigned     m_pre    = 0;
   int unsigned     m_pst    = 0;
   longint unsigned m_tim    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin : model
      logic v, r, xfer, ev, armed, last;
      if (!rst_n) begin
         m_active = 0; m_trg = 0; m_pend = 0; m_pre = 0; m_pst = 0; m_tim = 0;
      end
      check("sts_acq", sts_acq, m_active);
      check("sts_trg", sts_trg, m_trg);
      check("sts_pre", sts_pre, m_pre);
      check("sts_pst", sts_pst, m_pst);
`ifdef LA_ACQUIRE_TIMESTAMP_EN
      check("sts_tim", sts_tim, m_tim);
`endif
      check("sto_tvalid", sto_if.TVALID, m_active & sti_if.TVALID);
      check("sti_tready", sti_if.TREADY, m_active ? sto_if.TREADY : 1'b1);
      if (rst_n) begin
         v     = sti_if.TVALID;
         r     = m_active ? sto_if.TREADY : 1'b1;
         xfer  = v & r;
         ev    = ((|(trg_in & cfg_trg)) & v) | ctl_trg;
         armed = m_active && !m_trg && (m_pre >= cfg_pre);
         last  = 1'b0;
         if (m_active && !ctl_rst && !ctl_stp && v) begin
            if (armed && (ev || m_pend) && (cfg_pst == 0)) last = 1'b1;
            else if (m_trg && (m_pst == cfg_pst))          last = 1'b1;
         end
         if (m_active && xfer) exp_q.push_back('{data: sti_if.TDATA, last: last});

         if (ctl_rst) begin
            m_active = 0; m_trg = 0; m_pend = 0; m_pre = 0; m_pst = 0; m_tim = 0;
         end else if (!m_active) begin
            if (ctl_acq) begin
               m_active = 1; m_trg = 0; m_pend = 0; m_pre = 0; m_pst = 0; m_tim = 0;
            end
         end else if (ctl_stp) begin
            m_active = 0;
         end else if (!m_trg) begin
            if (!armed) begin
               if (xfer) m_pre++;
            end else if (xfer && (ev || m_pend)) begin
               m_trg = 1; m_pst = 1; m_pend = 0; m_tim = cyc;
               if (cfg_pst == 0) m_active = 0;
            end else begin
               if (ev) m_pend = 1;
               if (xfer && (m_pre < c_sat)) m_pre++;
            end
         end else if (xfer) begin
            if (m_pst == cfg_pst) m_active = 0;
            m_pst++;
         end
      end
   end

   always @(negedge clk) begin : monitor
      beat_t b;
      #1;
      if (rst_n && sto_if.TVALID && sto_if.TREADY) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_unexpected: got data %0h last %0b, expected no beat", sto_if.TDATA, sto_if.TLAST);
         end else begin
            b = exp_q.pop_front();
            check("beat_data", sto_if.TDATA, b.data);
            check("beat_last", sto_if.TLAST, b.last);
            if (sto_if.TLAST) n_last++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      ctl_acq = 0; ctl_stp = 0; ctl_trg = 0; ctl_rst = 0;
      trg_in = '0;
      sti_if.TDATA = $urandom;
   endtask

   initial begin
      ctl_rst = 0; ctl_acq = 0; ctl_stp = 0; ctl_trg = 0;
      cfg_trg = '0; cfg_pre = '0; cfg_pst = '0; trg_in = '0;
      sti_if.TVALID = 0; sti_if.TDATA = '0; sti_if.TKEEP = '1; sti_if.TLAST = 0;
      sto_if.TREADY = 1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      tick();
      check("rst_sts_acq", sts_acq, 0);
      check("rst_sts_trg", sts_trg, 0);
      check("rst_sts_pre", sts_pre, 0);
      check("rst_sts_pst", sts_pst, 0);
      check("rst_sti_tready", sti_if.TREADY, 1);

      // Basic packet: 10 pre beats, trigger beat 10, TLAST on beat 13.
      cfg_pre = 4; cfg_pst = 3; cfg_trg = 4'b0001;
      sti_if.TVALID = 1; sto_if.TREADY = 1;
      l0 = n_last;
      ctl_acq = 1; tick();
      for (int k = 0; k < 16; k++) begin
         if (k == 10) trg_in = 4'b0001;
         tick();
      end
      check("p1_sts_pre", sts_pre, 10);
      check("p1_sts_pst", sts_pst, 4);
      check("p1_sts_trg", sts_trg, 1);
      check("p1_sts_acq", sts_acq, 0);
      check("p1_last_count", n_last - l0, 1);

      // Triggers during pre-fill are ignored, software trigger then fires.
      cfg_pre = 8; cfg_pst = 2;
      l0 = n_last;
      ctl_acq = 1; tick();
      for (int k = 0; k < 20; k++) begin
         if (k == 2 || k == 5) trg_in = 4'b0001;
         tick();
      end
      check("p2_sts_trg_hold", sts_trg, 0);
      check("p2_sts_acq_hold", sts_acq, 1);
      check("p2_sts_pre_hold", sts_pre, 20);
      ctl_trg = 1; tick();
      check("p2_sts_trg", sts_trg, 1);
      check("p2_sts_pst", sts_pst, 1);
      repeat (4) tick();
      check("p2_sts_pst_end", sts_pst, 3);
      check("p2_sts_acq_end", sts_acq, 0);
      check("p2_last_count", n_last - l0, 1);

      // Pending trigger held across idle stream; single-beat packet.
      cfg_pre = 0; cfg_pst = 0; sti_if.TVALID = 0;
      l0 = n_last;
      ctl_acq = 1; tick();
      tick();
      ctl_trg = 1; tick();
      tick(); tick();
      check("p3_sts_trg_pend", sts_trg, 0);
      check("p3_sts_acq_pend", sts_acq, 1);
      sti_if.TVALID = 1; tick();
      check("p3_sts_trg", sts_trg, 1);
      check("p3_sts_pst", sts_pst, 1);
      check("p3_sts_acq", sts_acq, 0);
      check("p3_last_count", n_last - l0, 1);

      // Post run under random backpressure.
      cfg_pre = 2; cfg_pst = 5; cfg_trg = 4'b0010;
      l0 = n_last;
      ctl_acq = 1; tick();
      for (int k = 0; k < 100; k++) begin
         sto_if.TREADY = 1'($urandom_range(0, 1));
         if (k >= 6) trg_in = 4'b0010;
         tick();
      end
      sto_if.TREADY = 1;
      check("p4_sts_pst", sts_pst, 6);
      check("p4_sts_acq", sts_acq, 0);
      check("p4_last_count", n_last - l0, 1);

      // Stop mid post run, then restart clears status.
      cfg_pre = 1; cfg_pst = 6; cfg_trg = 4'b0001;
      l0 = n_last;
      ctl_acq = 1; tick();
      tick();
      trg_in = 4'b0001; tick();
      tick();
      ctl_stp = 1; tick();
      repeat (3) tick();
      check("p5_sts_acq", sts_acq, 0);
      check("p5_sts_pst", sts_pst, 2);
      check("p5_sts_trg", sts_trg, 1);
      check("p5_sts_pre", sts_pre, 1);
      check("p5_last_count", n_last - l0, 0);
      ctl_acq = 1; tick();
      check("p5_restart_pre", sts_pre, 0);
      check("p5_restart_pst", sts_pst, 0);
      check("p5_restart_trg", sts_trg, 0);
      ctl_stp = 1; tick();

      // Abort coinciding with the trigger beat.
      cfg_pre = 0; cfg_pst = 3;
      ctl_acq = 1; tick();
      tick();
      trg_in = 4'b0001; ctl_rst = 1; tick();
      check("p6_sts_acq", sts_acq, 0);
      check("p6_sts_trg", sts_trg, 0);
      check("p6_sts_pre", sts_pre, 0);
      check("p6_sts_pst", sts_pst, 0);
`ifdef LA_ACQUIRE_TIMESTAMP_EN
      check("p6_sts_tim", sts_tim, 0);
`endif

      // Pre-trigger counter saturation.
      cfg_pre = 1; cfg_pst = 0; cfg_trg = '0;
      ctl_acq = 1; tick();
      repeat (300) tick();
      check("sat_sts_pre", sts_pre, c_sat);
      check("sat_sts_acq", sts_acq, 1);
      ctl_trg = 1; tick();
      check("sat_sts_pre_end", sts_pre, c_sat);
      check("sat_sts_pst", sts_pst, 1);
      check("sat_sts_acq_end", sts_acq, 0);

      // Asynchronous reset mid-packet cuts the stream at once.
      cfg_pre = 0; cfg_pst = 20; cfg_trg = 4'b0001;
      ctl_acq = 1; tick();
      trg_in = 4'b0001; tick();
      tick(); tick();
      #2 rst_n = 0;
      #1;
      check("arst_sto_tvalid", sto_if.TVALID, 0);
      check("arst_sto_tlast", sto_if.TLAST, 0);
      check("arst_sts_acq", sts_acq, 0);
      check("arst_sts_pst", sts_pst, 0);
      @(posedge clk);
      #1 rst_n = 1;
      tick();

      // Randomized packets with random control pulses.
      for (int k = 0; k < 1500; k++) begin
         if (!m_active && $urandom_range(0, 7) == 0) begin
            cfg_pre = CW'($urandom_range(0, 6));
            cfg_pst = CW'($urandom_range(0, 6));
            cfg_trg = TN'($urandom);
         end
         if (!m_active && $urandom_range(0, 3) == 0) ctl_acq = 1;
         sti_if.TVALID = ($urandom_range(0, 3) != 0);
         sto_if.TREADY = ($urandom_range(0, 9) < 7);
         trg_in  = ($urandom_range(0, 5) == 0) ? TN'($urandom) : '0;
         ctl_trg = ($urandom_range(0, 39) == 0);
         ctl_stp = ($urandom_range(0, 99) == 0);
         ctl_rst = ($urandom_range(0, 149) == 0);
         tick();
      end
      ctl_stp = 1; tick();
      repeat (3) tick();
      check("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
